acc_cpu_controller: RTL

- Instruction-sequencing FSM for the 8-bit RISC CPU.
- Steps each instruction through fixed phases and drives the control strobes for the PC, IR, memory, data bus and accumulator.
- Its ld_ac output drives the accumulator's en_acc_in; its zero input comes from the accumulator output (acc_out == 0).
- Sits between the instruction register and the datapath.

---
 rtl/acc_cpu_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_controller.sv
// Instruction-sequencing FSM for the 8-bit accumulator RISC CPU: walks eight phases per instruction
// and decodes PC/IR/memory/bus/accumulator strobes. Optional memory stall: ACC_CTRL_MEM_STALL_EN.
module acc_cpu_controller #(
    parameter int unsigned OP_W        = 3,
    parameter int unsigned IDLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
`ifdef ACC_CTRL_MEM_STALL_EN
    input  logic            mem_ready,
`endif
    output logic            sel,
    output logic            rd,
    output logic            wr,
    output logic            ld_ir,
    output logic            inc_pc,
    output logic            ld_pc,
    output logic            ld_ac,
    output logic            data_e,
    output logic            halt,
    output logic [2:0]      phase
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    if (OP_W != 3) begin : g_op_w_chk
        $error("acc_cpu_controller: OP_W must be 3");
    end
    if (IDLE_CYCLES == 0 || IDLE_CYCLES > 15) begin : g_idle_chk
        $error("acc_cpu_controller: IDLE_CYCLES must be in 1..15");
    end

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             halted_q, halted_d;
    logic             mem_ok;
    logic             alu_op;
    logic             is_skz, is_sto, is_jmp;

`ifdef ACC_CTRL_MEM_STALL_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_skz = (opcode == OP_SKZ);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INST_ADDR;
            idle_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state: fixed phase ring, IDLE stretched by the counter, fetches optionally stalled
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        halted_d   = halted_q;
        if (!halted_q) begin
            case (state_q)
                INST_ADDR:  state_d = INST_FETCH;
                INST_FETCH: if (mem_ok) state_d = INST_LOAD;
                INST_LOAD:  state_d = IDLE;
                IDLE: begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_d = '0;
                        state_d    = OP_ADDR;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
                OP_ADDR: begin
                    if (opcode == OP_HLT) halted_d = 1'b1;
                    else                  state_d  = OP_FETCH;
                end
                OP_FETCH:   if (mem_ok || !alu_op) state_d = ALU_OP;
                ALU_OP:     state_d = STORE;
                STORE:      state_d = INST_ADDR;
                default:    state_d = INST_ADDR;
            endcase
        end
    end

    // Strobe decode; a halted CPU shows only halt
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (state_q)
                INST_ADDR:  sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH:   rd = alu_op;
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign phase = state_q;

endmodule
